easyaxi_rd_mst: RTL and testbench
=================================

EASYAXI_RD_MST -- requirements
Module: easyaxi_rd_mst

Interface
REQ-001 SHALL have parameter OST_DEPTH, default 8, giving max outstanding read bursts (power of 2, >=2); OST_CNT_W = clog2(OST_DEPTH).
REQ-002 SHALL size all AXI fields by the `AXI_ID_W, `AXI_ADDR_W, `AXI_LEN_W, `AXI_SIZE_W, `AXI_BURST_W, `AXI_DATA_W and `AXI_RESP_W macros.
REQ-003 SHALL run on one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 enable  in  1  gates acceptance of new commands and new AR issue.
REQ-007 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-008 cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst  in  AXI widths  burst descriptor.
REQ-009 axi_mst_arvalid out 1, axi_mst_arready in 1, axi_mst_arid/araddr/arlen/arsize/arburst out AXI widths.
REQ-010 axi_mst_rvalid in 1, axi_mst_rready out 1, axi_mst_rid/rdata/rresp/rlast in AXI widths.
REQ-011 ost_cnt  out  OST_CNT_W+1  bursts accepted and not yet completed.
REQ-012 err_cnt  out  16  saturating count of checked-beat errors.
REQ-013 beat_cnt  out  16  wrapping count of accepted R beats.
REQ-014 idle  out  1  high when ost_cnt == 0 and arvalid == 0.

Function
REQ-015 SHALL store each accepted command in a circular table of OST_DEPTH slots via set pointer; cmd_ready = enable & ~full.
REQ-016 SHALL issue AR from the oldest accepted-but-unissued slot (issue pointer), registered: arvalid and payload assert the cycle after the slot is filled, at the earliest.
REQ-017 SHALL hold arvalid and AR payload stable until arready; deasserting enable SHALL NOT drop an asserted arvalid, it only blocks the next issue.
REQ-018 SHALL drive axi_mst_rready = 1 whenever not in reset (R never back-pressured).
REQ-019 SHALL consume R beats in order against the oldest issued slot (head pointer) with a per-burst beat index starting at 0.
REQ-020 SHALL compute expected beat address: FIXED = start addr; INCR = aligned(start, 2^size) + index*2^size; WRAP = boundary + ((start - boundary + index*2^size) mod ((len+1)*2^size)), boundary = start rounded down to (len+1)*2^size.
REQ-021 SHALL flag a beat error when any holds: rresp != OKAY; rid != slot id; rlast != (index == len); rdata != zero-extended {slot id, expected addr}.
REQ-022 SHALL increment err_cnt by 1 per erroneous beat (max one per beat), saturating at 0xFFFF.
REQ-023 SHALL free the head slot and advance the head pointer on the beat with index == len, independent of rlast value.
REQ-024 An R beat with no issued slot outstanding SHALL be accepted, counted in beat_cnt, and counted as one error.
REQ-025 Command accept and slot free in the same cycle SHALL leave ost_cnt unchanged; full SHALL be ost_cnt == OST_DEPTH.
REQ-026 Pointers SHALL wrap modulo OST_DEPTH; slot reuse SHALL be allowed the cycle after free.

Reset
REQ-027 On rst: all pointers, slot valids, beat index, ost_cnt, err_cnt, beat_cnt = 0; arvalid = 0; AR payload = 0; cmd_ready = 0 during rst; idle = 1 the cycle after.
REQ-028 rst asserted mid-burst SHALL discard all outstanding state; beats arriving after release are handled per REQ-024.

Verification
REQ-029 INCR id=2 addr=0x100 len=3 size=2, slave returns correct data -> one AR with same fields; expected addrs 0x100,0x104,0x108,0x10C; err_cnt=0, beat_cnt=4, idle=1.
REQ-030 WRAP id=1 addr=0x108 len=3 size=2 -> expected addrs 0x108,0x10C,0x100,0x104; err_cnt=0.
REQ-031 arready held 0, 9 commands offered with enable=1 -> 8 accepted, cmd_ready=0, ost_cnt=8; release arready -> ARs issued in order, 8 bursts complete, ost_cnt=0.
REQ-032 INCR len=1, second beat rresp=SLVERR -> err_cnt=1; rlast low on final beat of next burst -> err_cnt=2, slot still freed.
REQ-033 rst pulsed after 2 of 4 beats -> ost_cnt=0, arvalid=0; 2 stray beats afterwards -> err_cnt=2, beat_cnt=2.
REQ-034 enable dropped while arvalid=1, arready=0 -> arvalid held until arready; no further AR or cmd accept while enable=0.

Source files
------------

// File: rtl/easyaxi_rd_mst.sv
// AXI read master: queues burst commands, issues AR in order and checks every returned R beat
// against the address and id the burst should produce.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 64
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_mst #(
  parameter int unsigned OST_DEPTH = 8,
  localparam int unsigned OST_CNT_W = $clog2(OST_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [`AXI_ID_W-1:0]    cmd_id,
  input  logic [`AXI_ADDR_W-1:0]  cmd_addr,
  input  logic [`AXI_LEN_W-1:0]   cmd_len,
  input  logic [`AXI_SIZE_W-1:0]  cmd_size,
  input  logic [`AXI_BURST_W-1:0] cmd_burst,
  output logic                    axi_mst_arvalid,
  input  logic                    axi_mst_arready,
  output logic [`AXI_ID_W-1:0]    axi_mst_arid,
  output logic [`AXI_ADDR_W-1:0]  axi_mst_araddr,
  output logic [`AXI_LEN_W-1:0]   axi_mst_arlen,
  output logic [`AXI_SIZE_W-1:0]  axi_mst_arsize,
  output logic [`AXI_BURST_W-1:0] axi_mst_arburst,
  input  logic                    axi_mst_rvalid,
  output logic                    axi_mst_rready,
  input  logic [`AXI_ID_W-1:0]    axi_mst_rid,
  input  logic [`AXI_DATA_W-1:0]  axi_mst_rdata,
  input  logic [`AXI_RESP_W-1:0]  axi_mst_rresp,
  input  logic                    axi_mst_rlast,
  output logic [OST_CNT_W:0]      ost_cnt,
  output logic [15:0]             err_cnt,
  output logic [15:0]             beat_cnt,
  output logic                    idle
);
  localparam int unsigned AW = `AXI_ADDR_W;
  localparam logic [`AXI_BURST_W-1:0] BurstIncr = `AXI_BURST_W'(1);
  localparam logic [`AXI_BURST_W-1:0] BurstWrap = `AXI_BURST_W'(2);

  logic [`AXI_ID_W-1:0]    slot_id_q    [OST_DEPTH];
  logic [`AXI_ADDR_W-1:0]  slot_addr_q  [OST_DEPTH];
  logic [`AXI_LEN_W-1:0]   slot_len_q   [OST_DEPTH];
  logic [`AXI_SIZE_W-1:0]  slot_size_q  [OST_DEPTH];
  logic [`AXI_BURST_W-1:0] slot_burst_q [OST_DEPTH];
  logic [OST_DEPTH-1:0]    slot_vld_q, slot_vld_d, slot_iss_q, slot_iss_d;
  logic [OST_CNT_W-1:0]    set_ptr_q, iss_ptr_q, head_ptr_q;
  logic [`AXI_LEN_W-1:0]   beat_idx_q;
  logic [OST_CNT_W:0]      ost_cnt_q;
  logic [15:0]             err_cnt_q, beat_cnt_q;
  logic                    arvalid_q;
  logic [`AXI_ID_W-1:0]    ar_id_q;
  logic [`AXI_ADDR_W-1:0]  ar_addr_q;
  logic [`AXI_LEN_W-1:0]   ar_len_q;
  logic [`AXI_SIZE_W-1:0]  ar_size_q;
  logic [`AXI_BURST_W-1:0] ar_burst_q;

  logic full, cmd_acc, ar_done, ar_load, r_acc, head_vld, last_idx, slot_free, beat_err;
  logic [`AXI_ID_W-1:0]    h_id;
  logic [`AXI_ADDR_W-1:0]  h_addr, step, size_b, wrap_b, wrap_lo, exp_addr;
  logic [`AXI_LEN_W-1:0]   h_len;
  logic [`AXI_SIZE_W-1:0]  h_size;
  logic [`AXI_BURST_W-1:0] h_burst;
  logic [`AXI_DATA_W-1:0]  exp_data;

  assign full      = ost_cnt_q == (OST_CNT_W + 1)'(OST_DEPTH);
  assign cmd_ready = enable & ~full & ~rst;
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign ar_done   = arvalid_q & axi_mst_arready;
  // A new AR may be loaded into the register as the previous one handshakes.
  assign ar_load   = enable & slot_vld_q[iss_ptr_q] & ~slot_iss_q[iss_ptr_q] &
                     (~arvalid_q | axi_mst_arready);
  assign r_acc     = axi_mst_rvalid & axi_mst_rready;
  assign head_vld  = slot_vld_q[head_ptr_q] & slot_iss_q[head_ptr_q];
  assign h_id      = slot_id_q[head_ptr_q];
  assign h_addr    = slot_addr_q[head_ptr_q];
  assign h_len     = slot_len_q[head_ptr_q];
  assign h_size    = slot_size_q[head_ptr_q];
  assign h_burst   = slot_burst_q[head_ptr_q];
  assign last_idx  = beat_idx_q == h_len;
  assign slot_free = r_acc & head_vld & last_idx;

  always_comb begin
    step     = AW'(beat_idx_q) << h_size;
    size_b   = AW'(1) << h_size;
    wrap_b   = (AW'(h_len) + AW'(1)) << h_size;
    wrap_lo  = h_addr & ~(wrap_b - AW'(1));
    exp_addr = h_addr;
    case (h_burst)
      BurstIncr: exp_addr = (h_addr & ~(size_b - AW'(1))) + step;
      BurstWrap: exp_addr = wrap_lo + ((h_addr - wrap_lo + step) & (wrap_b - AW'(1)));
      default:   exp_addr = h_addr;
    endcase
    exp_data = `AXI_DATA_W'({h_id, exp_addr});
    beat_err = ~head_vld | (axi_mst_rresp != '0) | (axi_mst_rid != h_id) |
               (axi_mst_rlast != last_idx) | (axi_mst_rdata != exp_data);
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_iss_d = slot_iss_q;
    if (slot_free) begin
      slot_vld_d[head_ptr_q] = 1'b0;
      slot_iss_d[head_ptr_q] = 1'b0;
    end
    if (ar_load) slot_iss_d[iss_ptr_q] = 1'b1;
    if (cmd_acc) begin
      slot_vld_d[set_ptr_q] = 1'b1;
      slot_iss_d[set_ptr_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_acc) begin
      slot_id_q[set_ptr_q]    <= cmd_id;
      slot_addr_q[set_ptr_q]  <= cmd_addr;
      slot_len_q[set_ptr_q]   <= cmd_len;
      slot_size_q[set_ptr_q]  <= cmd_size;
      slot_burst_q[set_ptr_q] <= cmd_burst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_q <= '0;
      slot_iss_q <= '0;
      set_ptr_q  <= '0;
      iss_ptr_q  <= '0;
      head_ptr_q <= '0;
      beat_idx_q <= '0;
      ost_cnt_q  <= '0;
      err_cnt_q  <= '0;
      beat_cnt_q <= '0;
      arvalid_q  <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_iss_q <= slot_iss_d;
      if (cmd_acc) set_ptr_q <= set_ptr_q + OST_CNT_W'(1);
      if (ar_load) begin
        iss_ptr_q  <= iss_ptr_q + OST_CNT_W'(1);
        arvalid_q  <= 1'b1;
        ar_id_q    <= slot_id_q[iss_ptr_q];
        ar_addr_q  <= slot_addr_q[iss_ptr_q];
        ar_len_q   <= slot_len_q[iss_ptr_q];
        ar_size_q  <= slot_size_q[iss_ptr_q];
        ar_burst_q <= slot_burst_q[iss_ptr_q];
      end else if (ar_done) begin
        arvalid_q <= 1'b0;
      end
      if (r_acc) begin
        beat_cnt_q <= beat_cnt_q + 16'd1;
        if (beat_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        // The burst ends on its index count; a wrong rlast is only reported as an error.
        if (head_vld) begin
          if (last_idx) begin
            head_ptr_q <= head_ptr_q + OST_CNT_W'(1);
            beat_idx_q <= '0;
          end else begin
            beat_idx_q <= beat_idx_q + `AXI_LEN_W'(1);
          end
        end
      end
      case ({cmd_acc, slot_free})
        2'b10:   ost_cnt_q <= ost_cnt_q + (OST_CNT_W + 1)'(1);
        2'b01:   ost_cnt_q <= ost_cnt_q - (OST_CNT_W + 1)'(1);
        default: ost_cnt_q <= ost_cnt_q;
      endcase
    end
  end

  assign axi_mst_arvalid = arvalid_q;
  assign axi_mst_arid    = ar_id_q;
  assign axi_mst_araddr  = ar_addr_q;
  assign axi_mst_arlen   = ar_len_q;
  assign axi_mst_arsize  = ar_size_q;
  assign axi_mst_arburst = ar_burst_q;
  assign axi_mst_rready  = ~rst;
  assign ost_cnt         = ost_cnt_q;
  assign err_cnt         = err_cnt_q;
  assign beat_cnt        = beat_cnt_q;
  assign idle            = (ost_cnt_q == '0) & ~arvalid_q;

endmodule

// File: tb/tb_easyaxi_rd_mst.sv
// Bench for easyaxi_rd_mst: scoreboarded AR checks plus a responding R slave model.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 64
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`timescale 1ns/1ps

module tb_easyaxi_rd_mst;
  localparam int AW = `AXI_ADDR_W;
  localparam int DW = `AXI_DATA_W;

  typedef struct {
    logic [`AXI_ID_W-1:0]    id;
    logic [`AXI_ADDR_W-1:0]  addr;
    logic [`AXI_LEN_W-1:0]   len;
    logic [`AXI_SIZE_W-1:0]  size;
    logic [`AXI_BURST_W-1:0] burst;
    int                      inj;  // 0 clean, 1 SLVERR on last beat, 2 rlast low on last beat
  } ar_t;

  logic clk = 1'b0;
  logic rst, enable, cmd_valid, cmd_ready;
  logic [`AXI_ID_W-1:0]    cmd_id;
  logic [`AXI_ADDR_W-1:0]  cmd_addr;
  logic [`AXI_LEN_W-1:0]   cmd_len;
  logic [`AXI_SIZE_W-1:0]  cmd_size;
  logic [`AXI_BURST_W-1:0] cmd_burst;
  logic arvalid, arready;
  logic [`AXI_ID_W-1:0]    arid;
  logic [`AXI_ADDR_W-1:0]  araddr;
  logic [`AXI_LEN_W-1:0]   arlen;
  logic [`AXI_SIZE_W-1:0]  arsize;
  logic [`AXI_BURST_W-1:0] arburst;
  logic rvalid, rready, rlast;
  logic [`AXI_ID_W-1:0]    rid;
  logic [`AXI_DATA_W-1:0]  rdata;
  logic [`AXI_RESP_W-1:0]  rresp;
  logic [3:0]  ost_cnt;
  logic [15:0] err_cnt, beat_cnt;
  logic idle;

  int checks = 0;
  int failures = 0;
  int exp_err = 0;
  int exp_beats = 0;
  ar_t ar_exp_q[$];
  ar_t sl_q[$];
  logic [`AXI_ADDR_W-1:0] addr_tbl_q[$];
  int flush_req = 0;
  int stray_beats = 0;
  bit have_cur = 0;

  easyaxi_rd_mst #(.OST_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .axi_mst_arvalid(arvalid), .axi_mst_arready(arready), .axi_mst_arid(arid),
    .axi_mst_araddr(araddr), .axi_mst_arlen(arlen), .axi_mst_arsize(arsize),
    .axi_mst_arburst(arburst),
    .axi_mst_rvalid(rvalid), .axi_mst_rready(rready), .axi_mst_rid(rid),
    .axi_mst_rdata(rdata), .axi_mst_rresp(rresp), .axi_mst_rlast(rlast),
    .ost_cnt(ost_cnt), .err_cnt(err_cnt), .beat_cnt(beat_cnt), .idle(idle)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [`AXI_ADDR_W-1:0] model_addr(ar_t b, int unsigned idx);
    longint unsigned nb, total, lo, a;
    nb = 64'd1 << b.size;
    a = 64'(b.addr);
    if (b.burst == 2'd1) begin
      a = (a / nb) * nb + 64'(idx) * nb;
    end else if (b.burst == 2'd2) begin
      total = nb * (64'(b.len) + 64'd1);
      lo = (a / total) * total;
      for (int unsigned k = 0; k < idx; k++) begin
        a = a + nb;
        if (a >= lo + total) a = lo;
      end
    end
    return a[AW-1:0];
  endfunction

  // Slave: acts 2ns after each falling edge so bench drives from the same edge are settled.
  initial begin : slave
    ar_t cur;
    ar_t e;
    int unsigned cur_idx;
    int flush_seen;
    int stray_done;
    logic [`AXI_ADDR_W-1:0] a;
    flush_seen = 0;
    stray_done = 0;
    cur_idx = 0;
    forever begin
      @(negedge clk);
      #2;
      if (flush_req != flush_seen) begin
        flush_seen = flush_req;
        sl_q.delete();
        have_cur = 0;
      end
      if (!have_cur && sl_q.size() > 0) begin
        cur = sl_q.pop_front();
        have_cur = 1;
        cur_idx = 0;
      end
      if (have_cur) begin
        if (addr_tbl_q.size() > 0) a = addr_tbl_q.pop_front();
        else a = model_addr(cur, cur_idx);
        rvalid = 1'b1;
        rid = cur.id;
        rdata = DW'({cur.id, a});
        rresp = '0;
        rlast = (cur_idx == 32'(cur.len));
        if (cur_idx == 32'(cur.len)) begin
          if (cur.inj == 1) rresp = 2'b10;
          if (cur.inj == 2) rlast = 1'b0;
          have_cur = 0;
        end
        cur_idx++;
      end else if (stray_beats > stray_done) begin
        rvalid = 1'b1;
        rid = '0;
        rdata = '0;
        rresp = '0;
        rlast = 1'b1;
        stray_done++;
      end else begin
        rvalid = 1'b0;
      end
      if (arvalid && arready) begin
        checks++;
        if (ar_exp_q.size() == 0) begin
          failures++;
          $display("FAIL ar_unexpected: got id=%0h addr=%0h len=%0d, required no AR",
                   arid, araddr, arlen);
        end else begin
          e = ar_exp_q.pop_front();
          if ({arid, araddr, arlen, arsize, arburst} !== {e.id, e.addr, e.len, e.size, e.burst}) begin
            failures++;
            $display("FAIL ar_fields: got id=%0h addr=%0h len=%0d size=%0d burst=%0d, required id=%0h addr=%0h len=%0d size=%0d burst=%0d",
                     arid, araddr, arlen, arsize, arburst, e.id, e.addr, e.len, e.size, e.burst);
          end
          sl_q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input int id, input int addr, input int len, input int size,
                          input int burst, input int inj, input int budget, output bit ok);
    ar_t e;
    tick();
    cmd_id = `AXI_ID_W'(id);
    cmd_addr = `AXI_ADDR_W'(addr);
    cmd_len = `AXI_LEN_W'(len);
    cmd_size = `AXI_SIZE_W'(size);
    cmd_burst = `AXI_BURST_W'(burst);
    cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (cmd_ready) begin
        ok = 1;
        e.id = cmd_id; e.addr = cmd_addr; e.len = cmd_len;
        e.size = cmd_size; e.burst = cmd_burst; e.inj = inj;
        ar_exp_q.push_back(e);
        tick();
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (ar_exp_q.size() == 0 && sl_q.size() == 0 && !have_cur && rvalid == 1'b0) begin
        done = 1;
        break;
      end
    end
    tick();
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: traffic still pending (ar_exp=%0d), required all bursts done",
               name, ar_exp_q.size());
    end
  endtask

  task automatic check_counts(input string name, input int ost);
    checks += 3;
    if (err_cnt !== 16'(exp_err)) begin
      failures++;
      $display("FAIL %s_err_cnt: got %0d, required %0d", name, err_cnt, exp_err);
    end
    if (beat_cnt !== 16'(exp_beats)) begin
      failures++;
      $display("FAIL %s_beat_cnt: got %0d, required %0d", name, beat_cnt, exp_beats);
    end
    if (ost_cnt !== 4'(ost)) begin
      failures++;
      $display("FAIL %s_ost_cnt: got %0d, required %0d", name, ost_cnt, ost);
    end
  endtask

  task automatic check_accept(input string name, input bit ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept: got cmd_ready never high, required command accepted", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) tick();
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_cmd_ready: got %b, required 0 during reset", cmd_ready);
    end
    rst = 1'b0;
    tick();
    checks += 4;
    if (idle !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle: got %b, required 1", idle);
    end
    if ({arvalid, arid, araddr, arlen, arsize, arburst} !== '0) begin
      failures++;
      $display("FAIL reset_ar: got valid=%b addr=%0h, required all zero", arvalid, araddr);
    end
    if (rready !== 1'b1) begin
      failures++;
      $display("FAIL reset_rready: got %b, required 1", rready);
    end
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready_after: got %b, required 1", cmd_ready);
    end
    check_counts("reset", 0);
  endtask

  task automatic test_incr();
    bit ok;
    addr_tbl_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    send_cmd(2, 'h100, 3, 2, 1, 0, 10, ok);
    check_accept("incr", ok);
    wait_quiet("incr");
    exp_beats += 4;
    check_counts("incr", 0);
    checks++;
    if (idle !== 1'b1) begin
      failures++;
      $display("FAIL incr_idle: got %b, required 1", idle);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    addr_tbl_q = '{32'h108, 32'h10C, 32'h100, 32'h104};
    send_cmd(1, 'h108, 3, 2, 2, 0, 10, ok);
    check_accept("wrap", ok);
    wait_quiet("wrap");
    exp_beats += 4;
    check_counts("wrap", 0);
  endtask

  task automatic test_full();
    bit ok;
    int acc;
    acc = 0;
    arready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send_cmd(i, 'h1000 + i * 'h40, 0, 3, 1, 0, 12, ok);
      if (ok) acc++;
    end
    tick();
    checks += 2;
    if (acc !== 8) begin
      failures++;
      $display("FAIL full_accepted: got %0d, required 8", acc);
    end
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_cmd_ready: got %b, required 0", cmd_ready);
    end
    check_counts("full_held", 8);
    arready = 1'b1;
    wait_quiet("full");
    exp_beats += 8;
    check_counts("full_drained", 0);
  endtask

  task automatic test_errors();
    bit ok;
    send_cmd(5, 'h40, 1, 2, 1, 1, 10, ok);
    check_accept("err_resp", ok);
    wait_quiet("err_resp");
    exp_beats += 2;
    exp_err += 1;
    check_counts("err_resp", 0);
    send_cmd(6, 'h80, 1, 2, 1, 2, 10, ok);
    check_accept("err_rlast", ok);
    wait_quiet("err_rlast");
    exp_beats += 2;
    exp_err += 1;
    check_counts("err_rlast", 0);
  endtask

  task automatic test_enable();
    bit ok, seen;
    arready = 1'b0;
    send_cmd(3, 'h200, 1, 2, 1, 0, 10, ok);
    check_accept("en_c1", ok);
    send_cmd(4, 'h300, 1, 2, 1, 0, 10, ok);
    check_accept("en_c2", ok);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (arvalid) begin
        seen = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL en_arvalid_timeout: got arvalid 0, required 1");
    end
    enable = 1'b0;
    cmd_id = 4'h9; cmd_addr = 32'h900; cmd_len = 8'd0; cmd_size = 3'd2; cmd_burst = 2'd1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks += 2;
      if (arvalid !== 1'b1) begin
        failures++;
        $display("FAIL en_arvalid_hold: got %b, required 1 (cycle %0d)", arvalid, i);
      end
      if (cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL en_cmd_ready: got %b, required 0 (cycle %0d)", cmd_ready, i);
      end
    end
    checks++;
    if (araddr !== 32'h200) begin
      failures++;
      $display("FAIL en_araddr: got %0h, required 200", araddr);
    end
    arready = 1'b1;
    repeat (6) tick();
    checks += 2;
    if (arvalid !== 1'b0) begin
      failures++;
      $display("FAIL en_no_issue: got arvalid %b, required 0 while disabled", arvalid);
    end
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL en_cmd_ready_late: got %b, required 0", cmd_ready);
    end
    exp_beats += 2;
    check_counts("en_disabled", 1);
    cmd_valid = 1'b0;
    enable = 1'b1;
    wait_quiet("en");
    exp_beats += 2;
    check_counts("en_resumed", 0);
  endtask

  task automatic test_rst_mid();
    bit ok, seen;
    send_cmd(7, 'h500, 3, 2, 1, 0, 10, ok);
    check_accept("rst_mid", ok);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (beat_cnt == 16'(exp_beats + 2)) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rst_mid_beats_timeout: got beat_cnt %0d, required %0d", beat_cnt,
               exp_beats + 2);
    end
    rst = 1'b1;
    flush_req++;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    exp_err = 0;
    exp_beats = 0;
    checks++;
    if (arvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_arvalid: got %b, required 0", arvalid);
    end
    check_counts("rst_mid_cleared", 0);
    stray_beats += 2;
    repeat (6) tick();
    exp_err = 2;
    exp_beats = 2;
    check_counts("rst_mid_stray", 0);
    checks++;
    if (idle !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_idle: got %b, required 1", idle);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    cmd_valid = 1'b0;
    cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    arready = 1'b1;
    rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_full();
    test_errors();
    test_enable();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
